// File: rtl/buffer_transp.sv
// N x N frame buffer: N rows in, then N rows (pass-through) or N columns (transpose) out; first vector the cycle after the last row.
// Backpressure: in_ready is low while draining, out_data holds under out_ready=0; BUFFER_TRANSP_FRAME_CNT_EN adds frame_cnt.
module buffer_transp #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    modo_leitura,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
`ifdef BUFFER_TRANSP_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         row_cnt;
  logic [CW-1:0]         col_cnt;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] mem [N][N];
  logic                  row_acc;
  logic                  vec_acc;
  logic                  row_end;
  logic                  col_end;

  assign row_acc = in_valid & in_ready;
  assign vec_acc = out_valid & out_ready;
  assign row_end = (row_cnt == LAST);
  assign col_end = (col_cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Handshakes are also gated by reset so that nothing looks ready while it is held low.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = enable & reset;
        if (row_acc && row_end) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = enable & reset;
        if (vec_acc && col_end) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
      col_cnt <= '0;
      mode_q  <= 1'b0;
    end else if (enable) begin
      if (row_acc) begin
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
        if (row_cnt == '0) begin
          mode_q <= modo_leitura;
        end
      end
      if (vec_acc) begin
        col_cnt <= col_end ? '0 : col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int i = 0; i < N; i++) begin
          mem[r][i] <= '0;
        end
      end
    end else if (enable && row_acc) begin
      for (int r = 0; r < N; r++) begin
        if (row_cnt == CW'(r)) begin
          for (int i = 0; i < N; i++) begin
            mem[r][i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Read side is a pure mux on col_cnt, so the vector holds for as long as col_cnt does.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < N; r++) begin
        if (mode_q) begin
          if (col_cnt == CW'(r)) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][r];
          end
        end else begin
          if (col_cnt == CW'(r)) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[r][i];
          end
        end
      end
    end
  end

  assign out_last = out_valid & col_end;
  assign busy     = (state == DRAIN) | (row_cnt != '0);

`ifdef BUFFER_TRANSP_FRAME_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (enable && vec_acc && col_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  cnt_range_a: assert property (@(posedge clock) disable iff (!reset)
    (row_cnt <= LAST) && (col_cnt <= LAST));

  out_hold_a: assert property (@(posedge clock) disable iff (!reset)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule
